bin_to_bcd_seq: RTL and testbench

//   Parametrised sequential binary-to-BCD converter (shift-add-3 / double-dabble), one bit per clock.

---
 rtl/bin_to_bcd_if.sv | 28 ++
 rtl/bin_to_bcd_seq.sv | 170 +++++++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/bin_to_bcd_if.sv
// Handshake bundle for the sequential binary-to-BCD converter.
// The master side offers a binary operand and takes the BCD result.
// The slave side is the converter.
interface bin_to_bcd_if #(
  parameter int IN_WIDTH = 14,
  parameter int DIGITS   = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [IN_WIDTH-1:0]   bin_in;
  logic                  signed_mode;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  neg;
  logic                  overflow;
  logic [DIGITS-1:0]     digit_en;

  modport master (
    output in_valid, bin_in, signed_mode, out_ready,
    input  in_ready, out_valid, bcd_out, neg, overflow, digit_en
  );

  modport slave (
    input  in_valid, bin_in, signed_mode, out_ready,
    output in_ready, out_valid, bcd_out, neg, overflow, digit_en
  );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter using shift-add-3 (double dabble),
// one input bit per clock. Handles optional two's-complement input,
// saturates to all nines when the magnitude does not fit in DIGITS digits,
// and flags significant (non-leading-zero) digits for display blanking.
module bin_to_bcd_seq #(
  parameter int IN_WIDTH = 14,
  parameter int DIGITS   = 4
) (
  input  logic        clk,
  input  logic        rst,
  bin_to_bcd_if.slave bus
);

  // Number of decimal digits needed to hold 2**w-1.
  function automatic int bin_digits(input int w);
    logic [63:0] v;
    int          d;
    v = (64'd1 << w) - 64'd1;
    d = 0;
    for (int i = 0; i < 20; i++) begin
      if (v != 64'd0) begin
        d++;
        v = v / 64'd10;
      end
    end
    return d;
  endfunction

  // Largest value representable in digs decimal digits.
  function automatic logic [63:0] full_scale(input int digs);
    logic [63:0] v;
    v = 64'd1;
    for (int i = 0; i < digs; i++) v = v * 64'd10;
    return v - 64'd1;
  endfunction

  // The accumulator is never narrower than the output so the output slice
  // is always available; unused upper digits simply stay zero.
  localparam int          BIN_DIGITS = bin_digits(IN_WIDTH);
  localparam int          ACC_DIGITS = (BIN_DIGITS > DIGITS) ? BIN_DIGITS : DIGITS;
  localparam int          ACC_W      = 4 * ACC_DIGITS;
  localparam int          CNT_W      = $clog2(IN_WIDTH + 1);
  localparam logic [63:0] FULL       = full_scale(DIGITS);

  // Add-3 correction: any digit >= 5 becomes >= 8 so the next shift carries.
  function automatic logic [ACC_W-1:0] add3(input logic [ACC_W-1:0] a);
    logic [ACC_W-1:0] r;
    r = a;
    for (int i = 0; i < ACC_DIGITS; i++) begin
      if (a[4*i +: 4] >= 4'd5) r[4*i +: 4] = a[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Saturation to all nines when the magnitude exceeds full scale.
  function automatic logic [4*DIGITS-1:0] sat_bcd(input logic [4*DIGITS-1:0] b,
                                                  input logic              ovf);
    return ovf ? {DIGITS{4'h9}} : b;
  endfunction

  // Marks every digit at or below the highest nonzero digit; ones always on.
  function automatic logic [DIGITS-1:0] lead_en(input logic [4*DIGITS-1:0] b);
    logic [DIGITS-1:0] en;
    logic              seen;
    seen = 1'b0;
    en   = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (b[4*i +: 4] != 4'd0) seen = 1'b1;
      en[i] = seen;
    end
    en[0] = 1'b1;
    return en;
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t              state_q, state_nx;
  logic [CNT_W-1:0]    cnt;
  logic [ACC_W-1:0]    acc, acc_nx;
  logic [IN_WIDTH-1:0] mag, mag_nx, mag_in;
  logic                neg_in, ovf_in, neg_lat, ovf_lat;
  logic                in_ready_c, out_valid_c;
  logic                accept, shift_en, load_out;
  logic [4*DIGITS-1:0] bcd_q;
  logic [DIGITS-1:0]   en_q;
  logic                neg_q, ovf_q;

  // Operand magnitude and overflow decision; the most negative input maps
  // to 2**(IN_WIDTH-1), which still fits the unsigned IN_WIDTH-bit magnitude.
  always_comb begin
    neg_in = bus.signed_mode & bus.bin_in[IN_WIDTH-1];
    mag_in = neg_in ? -bus.bin_in : bus.bin_in;
    ovf_in = {{(64-IN_WIDTH){1'b0}}, mag_in} > FULL;
    {acc_nx, mag_nx} = {add3(acc), mag} << 1;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_nx;
  end

  // Next-state and handshake decode.
  always_comb begin
    state_nx    = state_q;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) state_nx = S_SHIFT;
      end
      S_SHIFT: begin
        if (cnt == '0) state_nx = S_DONE;
      end
      S_DONE: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign accept   = in_ready_c & bus.in_valid;
  assign shift_en = (state_q == S_SHIFT) && (cnt != '0);
  assign load_out = (state_q == S_SHIFT) && (cnt == '0);

  // Remaining-bit counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           cnt <= '0;
    else if (accept)   cnt <= CNT_W'(IN_WIDTH);
    else if (shift_en) cnt <= cnt - CNT_W'(1);
  end

  // Operand capture on accept, then one double-dabble step per SHIFT cycle.
  always_ff @(posedge clk) begin
    if (accept) begin
      mag     <= mag_in;
      neg_lat <= neg_in;
      ovf_lat <= ovf_in;
      acc     <= '0;
    end else if (shift_en) begin
      acc <= acc_nx;
      mag <= mag_nx;
    end
  end

  // Result registers, loaded on entry to DONE and held until the next result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd_q <= '0;
      en_q  <= '0;
      neg_q <= 1'b0;
      ovf_q <= 1'b0;
    end else if (load_out) begin
      bcd_q <= sat_bcd(acc[4*DIGITS-1:0], ovf_lat);
      en_q  <= ovf_lat ? '1 : lead_en(acc[4*DIGITS-1:0]);
      neg_q <= neg_lat;
      ovf_q <= ovf_lat;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.bcd_out   = bcd_q;
  assign bus.digit_en  = en_q;
  assign bus.neg       = neg_q;
  assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Testbench for bin_to_bcd_seq: directed cases plus randomized operands
// compared against an arithmetic decimal-digit model.
module tb_bin_to_bcd_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bin_to_bcd_if #(.IN_WIDTH(14), .DIGITS(4))  ifa ();
  bin_to_bcd_if #(.IN_WIDTH(32), .DIGITS(10)) ifb ();

  bin_to_bcd_seq #(.IN_WIDTH(14), .DIGITS(4))  dut_a (.clk(clk), .rst(rst), .bus(ifa));
  bin_to_bcd_seq #(.IN_WIDTH(32), .DIGITS(10)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [39:0] bcd;
    logic        ng;
    logic        ov;
    logic [9:0]  en;
  } exp_t;

  // Reference: magnitude by integer arithmetic, digits by repeated /10.
  function automatic exp_t model(input longint unsigned val, input bit sgn,
                                 input int w, input int digs);
    exp_t            e;
    longint unsigned mag, full, m;
    int              hi;
    e.bcd = '0; e.en = '0; e.ng = 1'b0; e.ov = 1'b0;
    mag = val;
    if (sgn && (((val >> (w - 1)) & 64'd1) != 0)) begin
      mag  = (64'd1 << w) - val;
      e.ng = 1'b1;
    end
    full = 1;
    for (int i = 0; i < digs; i++) full = full * 10;
    full = full - 1;
    if (mag > full) begin
      e.ov = 1'b1;
      for (int i = 0; i < digs; i++) begin
        e.bcd[4*i +: 4] = 4'h9;
        e.en[i] = 1'b1;
      end
    end else begin
      hi = 0;
      m  = mag;
      for (int i = 0; i < digs; i++) begin
        e.bcd[4*i +: 4] = 4'(m % 10);
        if ((m % 10) != 0) hi = i;
        m = m / 10;
      end
      for (int i = 0; i < digs; i++) e.en[i] = (i <= hi);
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer an operand to converter A; returns #1 after the accept edge.
  task automatic a_send(input logic [13:0] v, input bit s);
    int n;
    n = 0;
    while (!ifa.in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    ifa.bin_in = v; ifa.signed_mode = s; ifa.in_valid = 1'b1;
    @(posedge clk); #1;
    ifa.in_valid = 1'b0;
  endtask

  task automatic a_wait(input string tag, input int exp_lat);
    int lat;
    lat = 0;
    while (!ifa.out_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    chk({tag, ".out_valid"}, 64'(ifa.out_valid), 64'd1);
    if (exp_lat > 0) chk({tag, ".latency"}, 64'(lat), 64'(exp_lat));
  endtask

  task automatic a_check(input string tag, input exp_t e);
    chk({tag, ".bcd"},      64'(ifa.bcd_out),  64'(e.bcd[15:0]));
    chk({tag, ".neg"},      64'(ifa.neg),      64'(e.ng));
    chk({tag, ".overflow"}, 64'(ifa.overflow), 64'(e.ov));
    chk({tag, ".digit_en"}, 64'(ifa.digit_en), 64'(e.en[3:0]));
  endtask

  task automatic a_ack(input string tag);
    ifa.out_ready = 1'b1;
    @(posedge clk); #1;
    ifa.out_ready = 1'b0;
    chk({tag, ".valid_drop"}, 64'(ifa.out_valid), 64'd0);
  endtask

  task automatic a_run(input logic [13:0] v, input bit s, input string tag);
    a_send(v, s);
    a_wait(tag, 15);
    a_check(tag, model(64'(v), s, 14, 4));
    a_ack(tag);
  endtask

  task automatic b_run(input logic [31:0] v, input bit s, input string tag);
    exp_t e;
    int   lat, n;
    n = 0;
    while (!ifb.in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    ifb.bin_in = v; ifb.signed_mode = s; ifb.in_valid = 1'b1;
    @(posedge clk); #1;
    ifb.in_valid = 1'b0;
    lat = 0;
    while (!ifb.out_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    chk({tag, ".latency"}, 64'(lat), 64'd33);
    e = model(64'(v), s, 32, 10);
    chk({tag, ".bcd"},      64'(ifb.bcd_out),  64'(e.bcd));
    chk({tag, ".neg"},      64'(ifb.neg),      64'(e.ng));
    chk({tag, ".overflow"}, 64'(ifb.overflow), 64'(e.ov));
    chk({tag, ".digit_en"}, 64'(ifb.digit_en), 64'(e.en));
    ifb.out_ready = 1'b1;
    @(posedge clk); #1;
    ifb.out_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t        e;
    logic [13:0] rv;
    logic [31:0] rw;
    bit          rs;

    rst = 1'b1;
    ifa.in_valid = 1'b0; ifa.bin_in = '0; ifa.signed_mode = 1'b0; ifa.out_ready = 1'b0;
    ifb.in_valid = 1'b0; ifb.bin_in = '0; ifb.signed_mode = 1'b0; ifb.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.in_ready",  64'(ifa.in_ready),  64'd1);
    chk("reset.out_valid", 64'(ifa.out_valid), 64'd0);
    chk("reset.bcd",       64'(ifa.bcd_out),   64'd0);
    chk("reset.digit_en",  64'(ifa.digit_en),  64'd0);
    chk("reset.overflow",  64'(ifa.overflow),  64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Full-scale value and 15-clock latency
    a_run(14'd9999, 1'b0, "t1_9999");
    chk("t1.const_bcd", 64'(ifa.bcd_out), 64'h9999);

    // Overflow saturation, then zero
    a_run(14'd10000, 1'b0, "t2_10000");
    a_run(14'd16383, 1'b0, "t2_16383");
    chk("t2.const_ovf", 64'(ifa.overflow), 64'd1);
    a_run(14'd0, 1'b0, "t2_zero");
    chk("t2.const_en", 64'(ifa.digit_en), 64'b0001);

    // Signed inputs, including the most negative value
    a_run(14'h3FF9, 1'b1, "t3_m7");
    a_run(14'h2000, 1'b1, "t3_min");
    chk("t3.const_bcd", 64'(ifa.bcd_out), 64'h8192);

    // Backpressure in DONE with a pending input
    a_send(14'd1234, 1'b0);
    a_wait("t4_first", 15);
    e = model(64'd1234, 1'b0, 14, 4);
    a_check("t4_first", e);
    ifa.bin_in = 14'd42; ifa.signed_mode = 1'b0; ifa.in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("t4.hold_valid", 64'(ifa.out_valid), 64'd1);
      chk("t4.hold_ready", 64'(ifa.in_ready),  64'd0);
      chk("t4.hold_bcd",   64'(ifa.bcd_out),   64'(e.bcd[15:0]));
    end
    ifa.out_ready = 1'b1;
    @(posedge clk); #1;
    ifa.out_ready = 1'b0;
    chk("t4.idle_valid", 64'(ifa.out_valid), 64'd0);
    chk("t4.idle_ready", 64'(ifa.in_ready),  64'd1);
    chk("t4.idle_bcd",   64'(ifa.bcd_out),   64'(e.bcd[15:0]));
    @(posedge clk); #1;
    ifa.in_valid = 1'b0;
    a_wait("t4_42", 15);
    a_check("t4_42", model(64'd42, 1'b0, 14, 4));
    chk("t4.const_en", 64'(ifa.digit_en), 64'b0011);
    a_ack("t4_42");

    // Reset in the middle of a conversion
    a_send(14'd1234, 1'b0);
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t5.out_valid", 64'(ifa.out_valid), 64'd0);
    chk("t5.bcd",       64'(ifa.bcd_out),   64'd0);
    chk("t5.in_ready",  64'(ifa.in_ready),  64'd1);
    rst = 1'b0;
    @(posedge clk); #1;
    a_run(14'd305, 1'b0, "t5_305");
    chk("t5.const_bcd", 64'(ifa.bcd_out), 64'h0305);

    // Randomized operands on the narrow converter
    for (int i = 0; i < 24; i++) begin
      rv = 14'($urandom_range(0, 16383));
      rs = 1'($urandom_range(0, 1));
      a_run(rv, rs, "rnd_a");
    end

    // Wide converter: 32-bit input, 10 digits
    b_run(32'hFFFF_FFFF, 1'b0, "t6_max");
    chk("t6.const_bcd", 64'(ifb.bcd_out), 64'h42_9496_7295);
    b_run(32'h8000_0000, 1'b1, "t6_min");
    for (int i = 0; i < 6; i++) begin
      rw = $urandom;
      rs = 1'($urandom_range(0, 1));
      b_run(rw, rs, "rnd_b");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
